// File: rtl/noc_avmm_pr_arbiter.sv
// Round-robin arbiter sharing one NoC AVMM master among partial-reconfiguration sectors.
// Frozen sectors are excluded from arbitration, and a lost read response is replaced after a timeout.
module noc_avmm_pr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int RD_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          freeze,
  input  logic [N_REQ-1:0]          s_read,
  input  logic [N_REQ-1:0]          s_write,
  input  logic [N_REQ*ADDR_W-1:0]   s_address,
  input  logic [N_REQ*DATA_W-1:0]   s_writedata,
  output logic [N_REQ-1:0]          s_waitrequest,
  output logic [DATA_W-1:0]         s_readdata,
  output logic [N_REQ-1:0]          s_readdatavalid,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_writedata,
  output logic                      m_read,
  output logic                      m_write,
  input  logic                      m_waitrequest,
  input  logic [DATA_W-1:0]         m_readdata,
  input  logic                      m_readdatavalid,
  output logic                      timeout_err,
  output logic [ID_W-1:0]           grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] rd_cnt;
  logic [N_REQ-1:0] req;
  logic             any_req;
  logic [ID_W-1:0]  pick;
  logic             accept;
  logic             timeout_hit;

  assign req = (s_read | s_write) & ~freeze;

  // Search starts just past the last served sector so every requester gets a turn.
  always_comb begin
    int idx;
    idx = 0;
    any_req = 1'b0;
    pick = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_waitrequest = '1;
    s_readdatavalid = '0;
    s_readdata = m_readdata;
    accept = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          accept = 1'b1;
          if (!freeze[grant_id]) s_waitrequest[grant_id] = 1'b0;
          state_nxt = m_write ? IDLE : RDWAIT;
        end
      end
      RDWAIT: begin
        if (m_readdatavalid) begin
          s_readdatavalid[grant_id] = 1'b1;
          state_nxt = IDLE;
        end else if (rd_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          s_readdata = TIMEOUT_DATA;
          s_readdatavalid[grant_id] = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A sector asserting read and write together is issued as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= ID_W'(N_REQ - 1);
      grant_id    <= '0;
      m_address   <= '0;
      m_writedata <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      rd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id    <= pick;
            m_address   <= s_address[int'(pick)*ADDR_W +: ADDR_W];
            m_writedata <= s_writedata[int'(pick)*DATA_W +: DATA_W];
            m_write     <= s_write[pick];
            m_read      <= ~s_write[pick];
          end
        end
        ISSUE: begin
          if (accept) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            rr_ptr  <= grant_id;
            rd_cnt  <= '0;
          end
        end
        RDWAIT: begin
          if (!m_readdatavalid) rd_cnt <= rd_cnt + 1'b1;
          if (timeout_hit) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_avmm_pr_arbiter.sv
// Self-checking bench for noc_avmm_pr_arbiter: a vector table for writes and round-robin order,
// then hand-written sequences for read latency, timeout, freeze and mid-transaction reset.
module tb_noc_avmm_pr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  freeze = '0;
  logic [3:0]  s_read = '0;
  logic [3:0]  s_write = '0;
  logic [79:0] s_address;
  logic [127:0] s_writedata;
  logic [3:0]  s_waitrequest;
  logic [31:0] s_readdata;
  logic [3:0]  s_readdatavalid;
  logic [19:0] m_address;
  logic [31:0] m_writedata;
  logic        m_read;
  logic        m_write;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic        timeout_err;
  logic [1:0]  grant_id;

  int total = 0;
  int bad = 0;

  logic [19:0] addr_tab [4];
  logic [31:0] data_tab [4];

  noc_avmm_pr_arbiter #(
    .N_REQ(4), .ADDR_W(20), .DATA_W(32), .RD_TIMEOUT(8), .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_read(m_read), .m_write(m_write),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .timeout_err(timeout_err), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] frz;
    logic [3:0] rd;
    logic [3:0] wr;
    logic       mwr;
    logic [3:0] exp_swait;
    logic       exp_mrd;
    logic       exp_mwr;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] frz, input logic [3:0] rd,
                               input logic [3:0] wr, input logic mwr, input logic mrdv,
                               input logic [31:0] mrdata);
    rst = r;
    freeze = frz;
    s_read = rd;
    s_write = wr;
    m_waitrequest = mwr;
    m_readdatavalid = mrdv;
    m_readdata = mrdata;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    addr_tab[0] = 20'h00A00; addr_tab[1] = 20'h00B10; addr_tab[2] = 20'h00100; addr_tab[3] = 20'h00D30;
    data_tab[0] = 32'h11110000; data_tab[1] = 32'h22221111; data_tab[2] = 32'hA5A5A5A5; data_tab[3] = 32'h44443333;
    s_address = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    s_writedata = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};

    // rst frz rd wr mwr | swait mrd mwr gid
    vecs.push_back('{1'b0, 4'b0, 4'b0, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b0100, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b0100, 1'b0, 4'b1011, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd2});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd2});
    vecs.push_back('{1'b0, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1110, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd1});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b0111, 1'b0, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd3});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1110, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd1});
    vecs.push_back('{1'b1, 4'b0, 4'b0, 4'b1011, 1'b0, 4'b0111, 1'b0, 1'b1, 2'd3});

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      applyStimulus(vecs[i].rst, vecs[i].frz, vecs[i].rd, vecs[i].wr, vecs[i].mwr, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d_swait", i), 32'(s_waitrequest), 32'(vecs[i].exp_swait));
      checkOutput($sformatf("vec%0d_mread", i), 32'(m_read), 32'(vecs[i].exp_mrd));
      checkOutput($sformatf("vec%0d_mwrite", i), 32'(m_write), 32'(vecs[i].exp_mwr));
      checkOutput($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(vecs[i].exp_gid));
      checkOutput($sformatf("vec%0d_rdv", i), 32'(s_readdatavalid), 32'h0);
      if (vecs[i].exp_mwr) begin
        checkOutput($sformatf("vec%0d_maddr", i), 32'(m_address), 32'(addr_tab[vecs[i].exp_gid]));
        checkOutput($sformatf("vec%0d_mdata", i), m_writedata, data_tab[vecs[i].exp_gid]);
      end
    end

    // Read with 3 cycles of backpressure, response 5 cycles after acceptance
    do_reset();
    applyStimulus(1'b1, 4'b0, 4'b0010, 4'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    checkOutput("rd_mread", 32'(m_read), 32'h1);
    checkOutput("rd_gid", 32'(grant_id), 32'h1);
    checkOutput("rd_maddr", 32'(m_address), 32'(addr_tab[1]));
    checkOutput("rd_swait_hold", 32'(s_waitrequest), 32'hF);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      checkOutput("rd_swait_hold", 32'(s_waitrequest), 32'hF);
      checkOutput("rd_mread_hold", 32'(m_read), 32'h1);
    end
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rd_accept", 32'(s_waitrequest), 32'hD);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("rd_wait_rdv", 32'(s_readdatavalid), 32'h0);
      if (k == 1) checkOutput("rd_mread_clr", 32'(m_read), 32'h0);
    end
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 32'h12345678);
    checkOutput("rd_rdv", 32'(s_readdatavalid), 32'h2);
    checkOutput("rd_data", s_readdata, 32'h12345678);
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rd_rdv_after", 32'(s_readdatavalid), 32'h0);

    // Timeout on a lost read response, then a late response is ignored
    do_reset();
    checkOutput("to_err_reset", 32'(timeout_err), 32'h0);
    applyStimulus(1'b1, 4'b0, 4'b0001, 4'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    checkOutput("to_accept", 32'(s_waitrequest), 32'hE);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("to_wait_rdv", 32'(s_readdatavalid), 32'h0);
    end
    next_cycle();
    checkOutput("to_rdv", 32'(s_readdatavalid), 32'h1);
    checkOutput("to_data", s_readdata, 32'hDEADBEEF);
    checkOutput("to_err_pre", 32'(timeout_err), 32'h0);
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 32'h0BADF00D);
    checkOutput("to_late_rdv", 32'(s_readdatavalid), 32'h0);
    checkOutput("to_err_set", 32'(timeout_err), 32'h1);
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'h1);

    // Frozen sector is not granted; freeze during its read wait still delivers data
    do_reset();
    checkOutput("fz_err_reset", 32'(timeout_err), 32'h0);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 4'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      checkOutput("fz_swait", 32'(s_waitrequest), 32'hF);
      checkOutput("fz_no_grant", 32'(m_read), 32'h0);
    end
    applyStimulus(1'b1, 4'b0000, 4'b1000, 4'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    checkOutput("fz_grant", 32'(m_read), 32'h1);
    checkOutput("fz_gid", 32'(grant_id), 32'h3);
    checkOutput("fz_accept", 32'(s_waitrequest), 32'h7);
    next_cycle();
    applyStimulus(1'b1, 4'b1000, 4'b0, 4'b0, 1'b0, 1'b1, 32'hCAFE0003);
    checkOutput("fz_rdv", 32'(s_readdatavalid), 32'h8);
    checkOutput("fz_data", s_readdata, 32'hCAFE0003);
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fz_rdv_after", 32'(s_readdatavalid), 32'h0);

    // Asynchronous reset while a write is stalled in ISSUE
    do_reset();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0100, 1'b1, 1'b0, 32'h0);
    next_cycle();
    checkOutput("mr_mwrite", 32'(m_write), 32'h1);
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0100, 1'b1, 1'b0, 32'h0);
    checkOutput("mr_mwrite_clr", 32'(m_write), 32'h0);
    checkOutput("mr_mread_clr", 32'(m_read), 32'h0);
    checkOutput("mr_swait", 32'(s_waitrequest), 32'hF);
    checkOutput("mr_gid", 32'(grant_id), 32'h0);
    next_cycle();
    applyStimulus(1'b1, 4'b0, 4'b0, 4'b1111, 1'b0, 1'b0, 32'h0);
    next_cycle();
    checkOutput("mr_first_write", 32'(m_write), 32'h1);
    checkOutput("mr_first_gid", 32'(grant_id), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
